// File: rtl/mem_bus_if_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_if_pkg
//   Shared definitions for the MEM-stage bus access unit: FSM state encodings,
//   default bus widths (the core's register-bus width) and a helper that sizes
//   the timeout counter.
// ----------------------------------------------------------------------------
package mem_bus_if_pkg;

    typedef enum logic [1:0] {
        MBI_IDLE = 2'd0,
        MBI_REQ  = 2'd1,
        MBI_WAIT = 2'd2,
        MBI_DONE = 2'd3
    } mbi_state_t;

    // Default widths follow the core register bus.
    localparam int MBI_ADDR_W = 32;
    localparam int MBI_DATA_W = 32;

    // Counter must hold values 0..timeout_cyc. A disabled timeout (0) still
    // keeps a 1-bit counter so no zero-width vectors appear.
    function automatic int mbi_cnt_w(input int timeout_cyc);
        return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// ----------------------------------------------------------------------------
// mem_bus_if
//   Data-memory access unit between the MEM stage and a valid/ready system bus.
//   Handles one outstanding transaction, stalls the pipeline until the slave
//   responds, and reports bus errors and timeouts.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_*_i           MEM-stage request (ce, we, addr, wdata, sel)
//   rdata_o           load data, valid in DONE, held until the next load
//   stallreq_o        combinational stall request to ctrl
//   err_o             one-cycle error pulse in DONE
//   err_addr_o        address of the most recent errored access
//   bus_valid_o       request valid toward the slave
//   bus_ready_i       slave accepts the request
//   bus_addr_o .. bus_sel_o   registered request fields
//   bus_rvalid_i      response valid (loads and stores)
//   bus_rdata_i       response data
//   bus_rerr_i        response error, qualified by bus_rvalid_i
//
// State | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no access in flight; req_ce_i latches a new request
// REQ   | bus_valid_o high, waiting for bus_ready_i
// WAIT  | request accepted, waiting for bus_rvalid_i
// DONE  | single completion cycle; stall released, rdata/err presented
// ----------------------------------------------------------------------------
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int ADDR_W      = MBI_ADDR_W,
    parameter int DATA_W      = MBI_DATA_W,   // multiple of 8
    parameter int TIMEOUT_CYC = 255           // 0 disables the timeout
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_ce_i,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_sel_i,

    output logic [DATA_W-1:0]     rdata_o,
    output logic                  stallreq_o,
    output logic                  err_o,
    output logic [ADDR_W-1:0]     err_addr_o,

    output logic                  bus_valid_o,
    input  logic                  bus_ready_i,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic                  bus_we_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_rerr_i
);

    localparam int CNT_W  = mbi_cnt_w(TIMEOUT_CYC);
    localparam bit TMO_EN = (TIMEOUT_CYC > 0);
    // The counter reaches TIMEOUT_CYC on the edge that leaves REQ/WAIT, so the
    // forced completion is decided while it still holds TIMEOUT_CYC-1.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    mbi_state_t       state;
    logic [CNT_W-1:0] cnt;

    logic in_flight;
    logic rsp_take;
    logic tmo_hit;
    logic cpl_err;

    always_comb begin
        in_flight = 1'b0;
        rsp_take  = 1'b0;
        tmo_hit   = 1'b0;
        cpl_err   = 1'b0;

        in_flight = (state == MBI_REQ) || (state == MBI_WAIT);

        // A zero-wait slave may accept and respond in the same REQ cycle.
        rsp_take = ((state == MBI_REQ) && bus_ready_i && bus_rvalid_i) ||
                   ((state == MBI_WAIT) && bus_rvalid_i);

        // A response arriving on the last allowed cycle still wins.
        tmo_hit = TMO_EN && in_flight && (cnt == CNT_LAST) && !rsp_take;

        cpl_err = tmo_hit || (rsp_take && bus_rerr_i);
    end

    // Must reach ctrl in the same cycle, so it cannot be registered.
    assign stallreq_o = req_ce_i & (state != MBI_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MBI_IDLE;
            cnt         <= '0;
            bus_valid_o <= 1'b0;
            bus_addr_o  <= '0;
            bus_we_o    <= 1'b0;
            bus_wdata_o <= '0;
            bus_sel_o   <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            err_addr_o  <= '0;
        end else begin
            err_o <= 1'b0;

            case (state)
                MBI_IDLE: begin
                    if (req_ce_i) begin
                        bus_addr_o  <= req_addr_i;
                        bus_we_o    <= req_we_i;
                        bus_wdata_o <= req_wdata_i;
                        bus_sel_o   <= req_sel_i;
                        cnt         <= '0;
                        bus_valid_o <= 1'b1;
                        state       <= MBI_REQ;
                    end
                end

                MBI_REQ, MBI_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (rsp_take || tmo_hit) begin
                        // Timeout only drops valid; the slave is not told.
                        state       <= MBI_DONE;
                        bus_valid_o <= 1'b0;
                        err_o       <= cpl_err;
                        if (cpl_err) begin
                            err_addr_o <= bus_addr_o;
                            rdata_o    <= '0;
                        end else if (!bus_we_o) begin
                            rdata_o <= bus_rdata_i;
                        end
                    end else if ((state == MBI_REQ) && bus_ready_i) begin
                        bus_valid_o <= 1'b0;
                        state       <= MBI_WAIT;
                    end
                end

                MBI_DONE: begin
                    // Always pass through IDLE so back-to-back requests never
                    // overlap bus_valid_o with the completing access.
                    state <= MBI_IDLE;
                end

                default: begin
                    state <= MBI_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_if
//   Self-checking bench for mem_bus_if. A table of accesses drives the main
//   instance (default timeout) with a scripted slave; expected completions go
//   into a scoreboard queue and are compared when the DUT reaches DONE.
//   Hand-written sequences cover reset mid-WAIT and the timeout path (second
//   instance with TIMEOUT_CYC=4).
// ----------------------------------------------------------------------------
module tb_mem_bus_if;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_ce, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;

    logic [31:0] rdata, err_addr, bus_addr, bus_wdata, bus_rdata;
    logic        stallreq, err, bus_valid, bus_ready, bus_we, bus_rvalid, bus_rerr;
    logic [3:0]  bus_sel;

    logic        t_ce, t_ready, t_rvalid, t_rerr;
    logic [31:0] t_rdata_in;
    logic [31:0] t_rdata, t_err_addr, t_bus_addr, t_bus_wdata;
    logic        t_stall, t_err, t_bus_valid, t_bus_we;
    logic [3:0]  t_bus_sel;

    mem_bus_if dut (
        .clk(clk), .rst(rst),
        .req_ce_i(req_ce), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_sel_i(req_sel),
        .rdata_o(rdata), .stallreq_o(stallreq), .err_o(err), .err_addr_o(err_addr),
        .bus_valid_o(bus_valid), .bus_ready_i(bus_ready), .bus_addr_o(bus_addr),
        .bus_we_o(bus_we), .bus_wdata_o(bus_wdata), .bus_sel_o(bus_sel),
        .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata), .bus_rerr_i(bus_rerr)
    );

    mem_bus_if #(.TIMEOUT_CYC(4)) dut_to (
        .clk(clk), .rst(rst),
        .req_ce_i(t_ce), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_sel_i(req_sel),
        .rdata_o(t_rdata), .stallreq_o(t_stall), .err_o(t_err), .err_addr_o(t_err_addr),
        .bus_valid_o(t_bus_valid), .bus_ready_i(t_ready), .bus_addr_o(t_bus_addr),
        .bus_we_o(t_bus_we), .bus_wdata_o(t_bus_wdata), .bus_sel_o(t_bus_sel),
        .bus_rvalid_i(t_rvalid), .bus_rdata_i(t_rdata_in), .bus_rerr_i(t_rerr)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          rdy;       // REQ cycles without ready before the accepting one
        int          rsp;       // cycles from accept to rvalid (0 = same cycle)
        logic [31:0] rsp_data;
        logic        rerr;
        int          done_cyc;  // cycle of DONE, counting the IDLE latch cycle as 1
        bit          keep_ce;   // hold req_ce high into the next access
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] err_addr;
    } sb_t;

    vec_t        vecs[8];
    sb_t         sb_q[$];
    sb_t         mon_e;
    logic [31:0] m_rdata, m_err_addr;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: a completion is visible as stall released while the
    // MEM stage is still requesting.
    always @(negedge clk) begin
        if (!rst && req_ce && !stallreq) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done rdata=%0h t=%0t", rdata, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_rdata", rdata, mon_e.rdata);
                chk("done_err", err, mon_e.err);
                chk("done_err_addr", err_addr, mon_e.err_addr);
            end
        end
    end

    task automatic do_access(input vec_t v);
        sb_t e;
        bit  done;
        int  done_at;
        e.err      = v.rerr;
        e.err_addr = v.rerr ? v.addr : m_err_addr;
        e.rdata    = v.rerr ? 32'h0 : (v.we ? m_rdata : v.rsp_data);
        m_rdata    = e.rdata;
        m_err_addr = e.err_addr;
        sb_q.push_back(e);

        req_ce = 1'b1; req_we = v.we; req_addr = v.addr;
        req_wdata = v.wdata; req_sel = v.sel;
        done = 1'b0; done_at = 0;
        for (int c = 1; c <= 24 && !done; c++) begin
            bus_ready  = (c == 2 + v.rdy);
            bus_rvalid = (v.rsp == 0) ? (c == 2 + v.rdy) : (c == 2 + v.rdy + v.rsp);
            bus_rdata  = bus_rvalid ? v.rsp_data : $urandom;
            bus_rerr   = bus_rvalid ? v.rerr : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!stallreq) begin
                done = 1'b1;
                done_at = c;
                chk("done_valid_low", bus_valid, 0);
            end else if (c >= 2 && c <= 2 + v.rdy) begin
                chk("req_valid", bus_valid, 1);
                chk("req_addr", bus_addr, v.addr);
                chk("req_we", bus_we, v.we);
                chk("req_wdata", bus_wdata, v.wdata);
                chk("req_sel", bus_sel, v.sel);
            end else begin
                chk("idle_wait_valid_low", bus_valid, 0);
            end
            @(posedge clk); #1;
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rerr = 1'b0;
        chk("done_cycle", done_at, v.done_cyc);
        if (!v.keep_ce) begin
            req_ce = 1'b0;
            @(negedge clk);
            chk("hold_rdata", rdata, m_rdata);
            chk("err_pulse_end", err, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int tdone;

        vecs[0] = '{we:1'b0, addr:32'h100,  wdata:32'h0,      sel:4'hF, rdy:0, rsp:0,
                    rsp_data:32'hDEADBEEF, rerr:1'b0, done_cyc:3, keep_ce:1'b0};
        vecs[1] = '{we:1'b1, addr:32'h200,  wdata:32'h0000ABCD, sel:4'b0011, rdy:1, rsp:3,
                    rsp_data:32'hFFFFFFFF, rerr:1'b0, done_cyc:7, keep_ce:1'b0};
        vecs[2] = '{we:1'b0, addr:32'h2000, wdata:32'h0,      sel:4'hF, rdy:0, rsp:2,
                    rsp_data:32'h55AA55AA, rerr:1'b1, done_cyc:5, keep_ce:1'b0};
        vecs[3] = '{we:1'b0, addr:32'h300,  wdata:32'h0,      sel:4'hF, rdy:2, rsp:0,
                    rsp_data:32'h0BADF00D, rerr:1'b0, done_cyc:5, keep_ce:1'b0};
        vecs[4] = '{we:1'b0, addr:32'h304,  wdata:32'h0,      sel:4'b1100, rdy:0, rsp:1,
                    rsp_data:32'hCAFEF00D, rerr:1'b0, done_cyc:4, keep_ce:1'b0};
        vecs[5] = '{we:1'b0, addr:32'h400,  wdata:32'h0,      sel:4'hF, rdy:0, rsp:0,
                    rsp_data:32'h11111111, rerr:1'b0, done_cyc:3, keep_ce:1'b1};
        vecs[6] = '{we:1'b0, addr:32'h404,  wdata:32'h0,      sel:4'hF, rdy:1, rsp:1,
                    rsp_data:32'h22222222, rerr:1'b0, done_cyc:5, keep_ce:1'b0};
        vecs[7] = '{we:1'b0, addr:32'h700,  wdata:32'h0,      sel:4'hF, rdy:0, rsp:0,
                    rsp_data:32'h0F0F0F0F, rerr:1'b0, done_cyc:3, keep_ce:1'b0};

        rst = 1'b1;
        req_ce = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_sel = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_rerr = 1'b0;
        t_ce = 1'b0; t_ready = 1'b0; t_rvalid = 1'b0; t_rdata_in = '0; t_rerr = 1'b0;
        m_rdata = '0; m_err_addr = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_sel", bus_sel, 0);
        chk("rst_stallreq", stallreq, 0);
        chk("rst_to_valid", t_bus_valid, 0);
        chk("rst_to_err", t_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) do_access(vecs[i]);

        // Reset while in WAIT, followed by a stray response in IDLE.
        req_ce = 1'b1; req_we = 1'b0; req_addr = 32'h600; req_sel = 4'hF; req_wdata = '0;
        @(posedge clk); #1;
        bus_ready = 1'b1;
        @(negedge clk);
        chk("rw_req_valid", bus_valid, 1);
        @(posedge clk); #1;
        bus_ready = 1'b0;
        @(negedge clk);
        chk("rw_wait_valid", bus_valid, 0);
        chk("rw_wait_stall", stallreq, 1);
        @(posedge clk); #1;
        rst = 1'b1; req_ce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0; bus_rerr = 1'b1;
        m_rdata = '0; m_err_addr = '0;
        @(negedge clk);
        chk("rw_rst_valid", bus_valid, 0);
        chk("rw_rst_addr", bus_addr, 0);
        chk("rw_rst_rdata", rdata, 0);
        chk("rw_rst_err", err, 0);
        chk("rw_rst_err_addr", err_addr, 0);
        chk("rw_rst_stall", stallreq, 0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0; bus_rerr = 1'b0;
        @(negedge clk);
        chk("rw_stray_err", err, 0);
        chk("rw_stray_rdata", rdata, 0);
        @(posedge clk); #1;
        do_access(vecs[7]);

        // Timeout instance: slave never ready.
        t_ce = 1'b1; req_we = 1'b0; req_addr = 32'h3000; req_sel = 4'hF;
        tdone = 0;
        for (int c = 1; c <= 12 && tdone == 0; c++) begin
            @(negedge clk);
            if (!t_stall) tdone = c;
            else if (c >= 2) chk("to_req_valid", t_bus_valid, 1);
            @(posedge clk); #1;
            if (tdone != 0) begin
                // tdone was sampled before this edge; recheck outputs held in DONE below
            end
        end
        chk("to_done_cycle", tdone, 6);
        // Outputs of the DONE cycle were registered; they are still visible
        // only in that cycle, so re-run the check through the pulse shape.
        @(negedge clk);
        chk("to_next_err_low", t_err, 0);
        chk("to_next_valid", t_bus_valid, 0);
        chk("to_next_stall", t_stall, 1);
        chk("to_err_addr", t_err_addr, 32'h3000);
        chk("to_rdata", t_rdata, 0);
        @(posedge clk); #1;
        // Cycle 7 (IDLE) latched 0x3000 again since t_ce stayed high; serve it.
        t_ready = 1'b1; t_rvalid = 1'b1; t_rdata_in = 32'h12345678; t_rerr = 1'b0;
        @(negedge clk);
        chk("to_svc_valid", t_bus_valid, 1);
        chk("to_svc_addr", t_bus_addr, 32'h3000);
        @(posedge clk); #1;
        t_ready = 1'b0; t_rvalid = 1'b0;
        @(negedge clk);
        chk("to_svc_done", t_stall, 0);
        chk("to_svc_rdata", t_rdata, 32'h12345678);
        chk("to_svc_err", t_err, 0);
        @(posedge clk); #1;
        t_ce = 1'b0;
        @(posedge clk); #1;

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // The timeout DONE cycle itself: err pulse and valid drop, sampled when
    // the timeout instance first releases its stall.
    always @(negedge clk) begin
        if (!rst && t_ce && !t_stall && t_err_addr == 32'h3000 && t_rdata == 32'h0) begin
            chk("to_done_err", t_err, 1);
            chk("to_done_valid", t_bus_valid, 0);
        end
    end

endmodule
